// File: rtl/ip_rewrite_table_req_sender.sv
// Initiator for the IP-rewrite table-adjust protocol: sends one header+data request
// to the lookup-table controller, waits for a single-flit ack, and reports done/err.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MSG_SRC_X_WIDTH
`define MSG_SRC_X_WIDTH 8
`endif
`ifndef MSG_SRC_Y_WIDTH
`define MSG_SRC_Y_WIDTH 8
`endif
`ifndef MSG_FBITS_WIDTH
`define MSG_FBITS_WIDTH 4
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif
`ifndef IP_REWRITE_ADJUST_TABLE
`define IP_REWRITE_ADJUST_TABLE 8'h2c
`endif
`ifndef IP_REWRITE_TABLE_CTRL_FBITS
`define IP_REWRITE_TABLE_CTRL_FBITS 2
`endif

module ip_rewrite_table_req_sender #(
   parameter int SRC_X          = -1,
   parameter int SRC_Y          = -1,
   parameter int SRC_FBITS      = 0,
   parameter int DST_X          = -1,
   parameter int DST_Y          = -1,
   parameter int DST_FBITS      = `IP_REWRITE_TABLE_CTRL_FBITS,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_val,
   input  logic [`IP_ADDR_W-1:0]       req_their_ip,
   input  logic [`PORT_NUM_W-1:0]      req_their_port,
   input  logic [`PORT_NUM_W-1:0]      req_our_port,
   input  logic [`IP_ADDR_W-1:0]       req_rewrite_addr,
   output logic                        req_rdy,
   output logic                        noc_out_val,
   output logic [`NOC_DATA_WIDTH-1:0]  noc_out_data,
   input  logic                        noc_out_rdy,
   input  logic                        noc_in_val,
   input  logic [`NOC_DATA_WIDTH-1:0]  noc_in_data,
   output logic                        noc_in_rdy,
   output logic                        done_val,
   output logic                        done_err,
   input  logic                        done_rdy
);
   localparam int XW    = `MSG_SRC_X_WIDTH;
   localparam int YW    = `MSG_SRC_Y_WIDTH;
   localparam int FW    = `MSG_FBITS_WIDTH;
   localparam int LEN_W = `MSG_LENGTH_WIDTH;
   localparam int TYP_W = `MSG_TYPE_WIDTH;
   localparam int DW    = `NOC_DATA_WIDTH;
   localparam int HDR_USED_W = 2 * (XW + YW + FW) + LEN_W + TYP_W;
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [XW-1:0]    SRC_X_T  = SRC_X[XW-1:0];
   localparam logic [YW-1:0]    SRC_Y_T  = SRC_Y[YW-1:0];
   localparam logic [FW-1:0]    SRC_F_T  = SRC_FBITS[FW-1:0];
   localparam logic [XW-1:0]    DST_X_T  = DST_X[XW-1:0];
   localparam logic [YW-1:0]    DST_Y_T  = DST_Y[YW-1:0];
   localparam logic [FW-1:0]    DST_F_T  = DST_FBITS[FW-1:0];
   localparam logic [TYP_W-1:0] ADJ_TYPE = `IP_REWRITE_ADJUST_TABLE;

   typedef struct packed {
      logic [XW-1:0]            dst_x;
      logic [YW-1:0]            dst_y;
      logic [FW-1:0]            dst_fbits;
      logic [LEN_W-1:0]         msg_len;
      logic [TYP_W-1:0]         msg_type;
      logic [XW-1:0]            src_x;
      logic [YW-1:0]            src_y;
      logic [FW-1:0]            src_fbits;
      logic [DW-HDR_USED_W-1:0] padding;
   } beehive_noc_hdr_flit;

   typedef struct packed {
      logic [`IP_ADDR_W-1:0]  their_ip;
      logic [`PORT_NUM_W-1:0] their_port;
      logic [`PORT_NUM_W-1:0] our_port;
      logic [`IP_ADDR_W-1:0]  rewrite_addr;
   } ip_rewrite_table_req;

   localparam int IP_REWRITE_TABLE_REQ_W = $bits(ip_rewrite_table_req);

   typedef enum logic [2:0] {
      IDLE, SEND_HDR, SEND_DATA, WAIT_RESP, DRAIN, DONE
   } state_e;

   state_e              state, state_next;
   ip_rewrite_table_req req_r;
   logic                err_r;
   logic [CNT_W-1:0]    tcnt;
   logic [LEN_W-1:0]    drain_cnt;

   beehive_noc_hdr_flit hdr_flit, resp_hdr;
   logic [DW-1:0]       data_flit;
   logic                resp_good, timeout_hit;
   logic                unused_resp_bits;

   always_comb begin
      hdr_flit           = '0;
      hdr_flit.dst_x     = DST_X_T;
      hdr_flit.dst_y     = DST_Y_T;
      hdr_flit.dst_fbits = DST_F_T;
      hdr_flit.src_x     = SRC_X_T;
      hdr_flit.src_y     = SRC_Y_T;
      hdr_flit.src_fbits = SRC_F_T;
      hdr_flit.msg_len   = LEN_W'(1);
      hdr_flit.msg_type  = ADJ_TYPE;
   end

   assign data_flit = {req_r, {(DW - IP_REWRITE_TABLE_REQ_W){1'b0}}};
   assign resp_hdr  = beehive_noc_hdr_flit'(noc_in_data);
   assign resp_good = (resp_hdr.msg_type == ADJ_TYPE) && (resp_hdr.src_x == DST_X_T) &&
                      (resp_hdr.src_y == DST_Y_T) && (resp_hdr.msg_len == '0);
   assign timeout_hit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign unused_resp_bits = ^{resp_hdr.dst_x, resp_hdr.dst_y, resp_hdr.dst_fbits,
                               resp_hdr.src_fbits, resp_hdr.padding};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Outputs are forced low during reset so req_rdy only rises once rst is released.
   always_comb begin
      state_next   = state;
      req_rdy      = 1'b0;
      noc_out_val  = 1'b0;
      noc_out_data = '0;
      noc_in_rdy   = 1'b0;
      done_val     = 1'b0;
      done_err     = 1'b0;
      unique case (state)
         IDLE: begin
            req_rdy    = 1'b1;
            noc_in_rdy = 1'b1;
            if (req_val) state_next = SEND_HDR;
         end
         SEND_HDR: begin
            noc_out_val  = 1'b1;
            noc_out_data = hdr_flit;
            if (noc_out_rdy) state_next = SEND_DATA;
         end
         SEND_DATA: begin
            noc_out_val  = 1'b1;
            noc_out_data = data_flit;
            if (noc_out_rdy) state_next = WAIT_RESP;
         end
         WAIT_RESP: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val)       state_next = (resp_hdr.msg_len != '0) ? DRAIN : DONE;
            else if (timeout_hit) state_next = DONE;
         end
         DRAIN: begin
            noc_in_rdy = 1'b1;
            if (noc_in_val && drain_cnt == LEN_W'(1)) state_next = DONE;
         end
         DONE: begin
            done_val = 1'b1;
            done_err = err_r;
            if (done_rdy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         req_rdy      = 1'b0;
         noc_out_val  = 1'b0;
         noc_out_data = '0;
         noc_in_rdy   = 1'b0;
         done_val     = 1'b0;
         done_err     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_r     <= '0;
         err_r     <= 1'b0;
         tcnt      <= '0;
         drain_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: if (req_val) begin
               req_r.their_ip     <= req_their_ip;
               req_r.their_port   <= req_their_port;
               req_r.our_port     <= req_our_port;
               req_r.rewrite_addr <= req_rewrite_addr;
            end
            SEND_DATA: if (noc_out_rdy) tcnt <= '0;
            WAIT_RESP: begin
               tcnt <= tcnt + CNT_W'(1);
               if (noc_in_val) begin
                  err_r <= ~resp_good;
                  if (resp_hdr.msg_len != '0) drain_cnt <= resp_hdr.msg_len;
               end else if (timeout_hit) begin
                  err_r <= 1'b1;
               end
            end
            DRAIN: if (noc_in_val) drain_cnt <= drain_cnt - LEN_W'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ip_rewrite_table_req_sender.sv
// Directed plus randomized bench for ip_rewrite_table_req_sender with a transaction-level model.
module tb_ip_rewrite_table_req_sender;
   localparam int DW = 512;
   localparam int T  = 16;
   localparam logic [7:0] SX = 8'hFF, SY = 8'h02, DX = 8'h03, DY = 8'h04, MT = 8'h2C;
   localparam logic [3:0] SF = 4'h0, DF = 4'h5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_val = 1'b0;
   logic [31:0]    req_their_ip = '0;
   logic [15:0]    req_their_port = '0;
   logic [15:0]    req_our_port = '0;
   logic [31:0]    req_rewrite_addr = '0;
   logic           req_rdy;
   logic           noc_out_val;
   logic [DW-1:0]  noc_out_data;
   logic           noc_out_rdy = 1'b0;
   logic           noc_in_val = 1'b0;
   logic [DW-1:0]  noc_in_data = '0;
   logic           noc_in_rdy;
   logic           done_val;
   logic           done_err;
   logic           done_rdy = 1'b0;

   int total = 0;
   int bad   = 0;

   ip_rewrite_table_req_sender #(
      .SRC_X(-1), .SRC_Y(2), .SRC_FBITS(0),
      .DST_X(3), .DST_Y(4), .DST_FBITS(5),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst),
      .req_val(req_val), .req_their_ip(req_their_ip), .req_their_port(req_their_port),
      .req_our_port(req_our_port), .req_rewrite_addr(req_rewrite_addr), .req_rdy(req_rdy),
      .noc_out_val(noc_out_val), .noc_out_data(noc_out_data), .noc_out_rdy(noc_out_rdy),
      .noc_in_val(noc_in_val), .noc_in_data(noc_in_data), .noc_in_rdy(noc_in_rdy),
      .done_val(done_val), .done_err(done_err), .done_rdy(done_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_hdr(input logic [7:0] dx, input logic [7:0] dy,
         input logic [3:0] df, input logic [21:0] len, input logic [7:0] typ,
         input logic [7:0] sx, input logic [7:0] sy, input logic [3:0] sf);
      return {dx, dy, df, len, typ, sx, sy, sf, {(DW-70){1'b0}}};
   endfunction

   function automatic logic [DW-1:0] rand_wide();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_rdy"}, req_rdy, 0);
      chk({tag, "_out_val"}, noc_out_val, 0);
      chk({tag, "_out_data"}, noc_out_data, 0);
      chk({tag, "_in_rdy"}, noc_in_rdy, 0);
      chk({tag, "_done_val"}, done_val, 0);
      chk({tag, "_done_err"}, done_err, 0);
   endtask

   // rd < 0 means no response (timeout); otherwise the response is presented rd cycles after
   // the first WAIT cycle, followed by rlen trailing flits.
   task automatic run_txn(input logic [31:0] ip, input logic [15:0] tp, input logic [15:0] op,
         input logic [31:0] ra, input int hs, input int ds, input int rd,
         input logic [7:0] rtyp, input logic [7:0] rsx, input logic [7:0] rsy,
         input logic [21:0] rlen, input int dstall);
      logic [DW-1:0] eh, ed, rf;
      logic eerr;
      int n;
      eh = mk_hdr(DX, DY, DF, 22'd1, MT, SX, SY, SF);
      ed = {ip, tp, op, ra, {(DW-96){1'b0}}};
      eerr = (rd < 0) || !(rtyp == MT && rsx == DX && rsy == DY && rlen == 0);

      chk("idle_req_rdy", req_rdy, 1);
      chk("idle_out_val", noc_out_val, 0);
      req_val = 1'b1; req_their_ip = ip; req_their_port = tp;
      req_our_port = op; req_rewrite_addr = ra;
      step();
      req_val = 1'b0;
      req_their_ip = $urandom; req_their_port = 16'($urandom);
      req_our_port = 16'($urandom); req_rewrite_addr = $urandom;

      for (int i = 0; i < hs; i++) begin
         chk("hdr_hold_val", noc_out_val, 1);
         chk("hdr_hold_data", noc_out_data, eh);
         chk("hdr_req_rdy", req_rdy, 0);
         step();
      end
      chk("hdr_val", noc_out_val, 1);
      chk("hdr_data", noc_out_data, eh);
      chk("hdr_in_rdy", noc_in_rdy, 0);
      noc_out_rdy = 1'b1;
      step();
      noc_out_rdy = 1'b0;

      for (int i = 0; i < ds; i++) begin
         chk("data_hold_val", noc_out_val, 1);
         chk("data_hold_data", noc_out_data, ed);
         step();
      end
      chk("data_val", noc_out_val, 1);
      chk("data_data", noc_out_data, ed);
      noc_out_rdy = 1'b1;
      step();
      noc_out_rdy = 1'b0;

      if (rd < 0) begin
         n = 1;
         while (!done_val && n < 4*T) begin
            step();
            n++;
         end
         chk("timeout_latency", n, T+1);
      end else begin
         for (int d = 0; d < rd; d++) begin
            chk("wait_in_rdy", noc_in_rdy, 1);
            chk("wait_done_val", done_val, 0);
            step();
         end
         chk("wait_out_val", noc_out_val, 0);
         rf = mk_hdr(8'($urandom), 8'($urandom), 4'($urandom), rlen, rtyp, rsx, rsy, 4'($urandom));
         rf[DW-71:0] = rand_wide() >> 70;
         noc_in_val = 1'b1;
         noc_in_data = rf;
         chk("resp_in_rdy", noc_in_rdy, 1);
         step();
         for (int k = 0; k < int'(rlen); k++) begin
            noc_in_data = rand_wide();
            chk("drain_in_rdy", noc_in_rdy, 1);
            chk("drain_done_val", done_val, 0);
            step();
         end
         noc_in_val = 1'b0;
      end

      for (int s = 0; s < dstall; s++) begin
         chk("done_hold_val", done_val, 1);
         chk("done_hold_err", done_err, eerr);
         chk("done_req_rdy", req_rdy, 0);
         chk("done_in_rdy", noc_in_rdy, 0);
         step();
      end
      chk("done_val", done_val, 1);
      chk("done_err", done_err, eerr);
      done_rdy = 1'b1;
      step();
      done_rdy = 1'b0;
      chk("after_done_val", done_val, 0);
      chk("after_req_rdy", req_rdy, 1);
   endtask

   initial begin
      int kind, hs, ds, rd, dst;
      logic [7:0] rtyp, rsx, rsy;
      logic [21:0] rlen;

      @(negedge clk);
      chk_all_zero("reset");
      step();
      chk_all_zero("reset2");
      rst = 1'b0;
      #1;
      chk("post_reset_req_rdy", req_rdy, 1);
      @(negedge clk);

      // basic zero-stall transaction, good response
      run_txn(32'h0A000001, 16'h1234, 16'h0050, 32'hC0A80001, 0, 0, 0, MT, DX, DY, 22'd0, 0);
      // backpressure on header, data, and done
      run_txn(32'h01020304, 16'hABCD, 16'h0F0F, 32'h05060708, 5, 3, 2, MT, DX, DY, 22'd0, 4);
      // timeout, then a late response dropped in IDLE
      run_txn(32'hDEADBEEF, 16'h0001, 16'h0002, 32'hCAFEF00D, 0, 0, -1, MT, DX, DY, 22'd0, 1);
      noc_in_val = 1'b1;
      noc_in_data = mk_hdr(SX, SY, SF, 22'd0, MT, DX, DY, DF);
      chk("late_in_rdy", noc_in_rdy, 1);
      step();
      noc_in_val = 1'b0;
      chk("late_done_val", done_val, 0);
      chk("late_req_rdy", req_rdy, 1);
      run_txn(32'h11111111, 16'h2222, 16'h3333, 32'h44444444, 0, 0, 1, MT, DX, DY, 22'd0, 0);
      // malformed responses
      run_txn(32'h0A0A0A0A, 16'h0B0B, 16'h0C0C, 32'h0D0D0D0D, 0, 0, 0, 8'h2D, DX, DY, 22'd0, 0);
      run_txn(32'h0A0A0A0B, 16'h0B0C, 16'h0C0D, 32'h0D0D0D0E, 0, 0, 0, MT, 8'h07, DY, 22'd0, 0);
      run_txn(32'h12345678, 16'h9ABC, 16'hDEF0, 32'h0FEDCBA9, 0, 0, 0, MT, DX, DY, 22'd2, 0);
      // response in the timeout cycle wins
      run_txn(32'hA5A5A5A5, 16'h5A5A, 16'hA5A5, 32'h5A5A5A5A, 0, 0, T-1, MT, DX, DY, 22'd0, 0);

      // reset while the data flit is pending
      req_val = 1'b1; req_their_ip = 32'h99999999; req_their_port = 16'h8888;
      req_our_port = 16'h7777; req_rewrite_addr = 32'h66666666;
      step();
      req_val = 1'b0;
      noc_out_rdy = 1'b1;
      step();
      noc_out_rdy = 1'b0;
      chk("rst_pre_data_val", noc_out_val, 1);
      rst = 1'b1;
      step();
      chk_all_zero("mid_reset");
      rst = 1'b0;
      #1;
      chk("rst_release_req_rdy", req_rdy, 1);
      chk("rst_release_out_val", noc_out_val, 0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_no_done", done_val, 0);
         chk("rst_no_out", noc_out_val, 0);
         step();
      end
      run_txn(32'h0A000002, 16'h4321, 16'h0051, 32'hC0A80002, 0, 0, 0, MT, DX, DY, 22'd0, 0);

      for (int it = 0; it < 24; it++) begin
         kind = $urandom_range(0, 6);
         hs = $urandom_range(0, 2);
         ds = $urandom_range(0, 2);
         dst = $urandom_range(0, 2);
         rd = $urandom_range(0, T-1);
         rtyp = MT; rsx = DX; rsy = DY; rlen = 22'd0;
         case (kind)
            2: rtyp = MT ^ 8'($urandom_range(1, 255));
            3: rsx = DX ^ 8'($urandom_range(1, 255));
            4: rsy = DY ^ 8'($urandom_range(1, 255));
            5: rlen = 22'($urandom_range(1, 3));
            6: rd = -1;
            default: ;
         endcase
         run_txn($urandom, 16'($urandom), 16'($urandom), $urandom, hs, ds, rd,
                 rtyp, rsx, rsy, rlen, dst);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
